ring_sequence_checker: RTL

- Receive-side monitor for a one-hot ring counter bus.
- Samples the ring word, decodes it to a binary index, checks one-hot legality and correct rotation, and maintains lock status plus an error count.
- Sits downstream of any ring counter stage; feeds status and debug logic.

---
 rtl/ring_sequence_checker.sv | 110 +++++++++++
 1 files changed

// File: rtl/ring_sequence_checker.sv
// rtl/ring_sequence_checker.sv - one-hot ring counter monitor: decode, rotation check, lock FSM, error count
// Optional: RING_CHK_ALLOW_HOLD_EN accepts a repeated word in ACQUIRE/LOCKED as a held counter.
module ring_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           ring_in,
  input  logic                       ring_valid,
  output logic [$clog2(WIDTH)-1:0]   index,
  output logic                       onehot_ok,
  output logic                       locked,
  output logic                       seq_err,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic [CNT_W-1:0]   adv_q, adv_d;
  logic               err_d;
  logic               is_onehot;
  logic               match;
  logic               hold_ok;
  logic [IDX_W-1:0]   idx_dec;

  assign is_onehot = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
  assign match     = (ring_in == {ref_q[WIDTH-2:0], ref_q[WIDTH-1]});

`ifdef RING_CHK_ALLOW_HOLD_EN
  assign hold_ok = (ring_in == ref_q);
`else
  assign hold_ok = 1'b0;
`endif

  always_comb begin
    idx_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) idx_dec = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    adv_d   = adv_q;
    err_d   = 1'b0;
    if (ring_valid) begin
      case (state_q)
        SEARCH: begin
          if (is_onehot) begin
            ref_d   = ring_in;
            adv_d   = '0;
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (match) begin
            ref_d = ring_in;
            adv_d = adv_q + CNT_W'(1);
            if (adv_q == CNT_W'(LOCK_COUNT - 1)) state_d = LOCKED;
          end else if (!hold_ok) begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (match) begin
            ref_d = ring_in;
          end else if (!hold_ok) begin
            err_d   = 1'b1;
            state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      ref_q     <= '0;
      adv_q     <= '0;
      index     <= '0;
      onehot_ok <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      adv_q   <= adv_d;
      seq_err <= err_d;
      if (ring_valid) begin
        onehot_ok <= is_onehot;
        if (is_onehot) index <= idx_dec;
      end
      // Saturate rather than wrap so a long-running fault stays visible.
      if (err_d && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign locked = (state_q == LOCKED);

endmodule
